// File: rtl/ram_fifo_pkg.sv
// Shared constants and the grant encoding for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WR,
    GNT_RD
  } gnt_e;

  function automatic logic is_full(input logic [AW:0] count);
    return count == (AW + 1)'(DEPTH);
  endfunction

endpackage

// File: rtl/ram_fifo_arb.sv
// Two-way round-robin arbiter for the single RAM port: a contested cycle goes
// to whichever side lost the previous contested cycle.
module ram_fifo_arb
  import ram_fifo_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic wr_req,
  input  logic rd_req,
  output gnt_e gnt
);

  logic last_rd;

  always_comb begin
    gnt = GNT_NONE;
    if (wr_req && rd_req) begin
      gnt = last_rd ? GNT_WR : GNT_RD;
    end else if (wr_req) begin
      gnt = GNT_WR;
    end else if (rd_req) begin
      gnt = GNT_RD;
    end
  end

  // Uncontested grants leave the history alone so alternation only tracks real conflicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd <= 1'b1;
    end else if (wr_req && rd_req) begin
      last_rd <= (gnt == GNT_RD);
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller over one port of the 8-bit RAM: owns the pointers,
// occupancy and the output-valid flag; the RAM's registered dout is the pop data.
module ram_fifo_ctrl #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          ram_en,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [AW:0]   level
);

  import ram_fifo_pkg::*;

  localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic [AW:0]   ram_count;
  logic          wr_req;
  logic          rd_req;
  logic          wr_gnt;
  logic          rd_gnt;
  gnt_e          gnt;

  assign wr_req = s_valid && (ram_count != FULL_COUNT);
  assign rd_req = (ram_count != '0) && (!m_valid || m_ready);

  ram_fifo_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_req (wr_req),
    .rd_req (rd_req),
    .gnt    (gnt)
  );

  // Grants are qualified by rst_n so nothing reaches the RAM or upstream while in reset.
  assign wr_gnt  = rst_n && (gnt == GNT_WR);
  assign rd_gnt  = rst_n && (gnt == GNT_RD);
  assign s_ready = wr_gnt;
  assign ram_en  = wr_gnt || rd_gnt;
  assign ram_wr  = wr_gnt;
  assign m_data  = ram_dout;
  assign level   = ram_count + (AW + 1)'(m_valid);

  always_comb begin
    ram_addr = addr_q;
    ram_din  = din_q;
    if (wr_gnt) begin
      ram_addr = wptr;
      ram_din  = s_data;
    end else if (rd_gnt) begin
      ram_addr = rptr;
    end
  end

  // A read grant refills the output in the same edge a pop drains it, giving full-rate pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      ram_count <= '0;
      m_valid   <= 1'b0;
    end else begin
      if (ram_en) begin
        addr_q <= ram_addr;
      end
      if (wr_gnt) begin
        wptr      <= wptr + AW'(1);
        din_q     <= s_data;
        ram_count <= ram_count + (AW + 1)'(1);
      end
      if (rd_gnt) begin
        rptr      <= rptr + AW'(1);
        ram_count <= ram_count - (AW + 1)'(1);
        m_valid   <= 1'b1;
      end else if (m_ready) begin
        m_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural registered-read RAM and
// an in-order scoreboard on every completed pop.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       ram_en;
  logic       ram_wr;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout = 8'h00;
  logic [8:0] level;

  logic [7:0] mem [256];
  logic [7:0] sb_queue [$];

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DW(8), .AW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .ram_en   (ram_en),
    .ram_wr   (ram_wr),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .level    (level)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [7:0] sd, input logic mr);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
  endtask

  always @(negedge rst_n) sb_queue.delete();

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (s_valid && s_ready) sb_queue.push_back(s_data);
      if (m_valid && m_ready) begin
        checkOutput("sb_nonempty", 32'(sb_queue.size() != 0), 1);
        if (sb_queue.size() != 0) checkOutput("sb_data", m_data, sb_queue.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] d);
    bit accepted = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (s_ready) accepted = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    checkOutput("push_accept", 32'(accepted), 1);
  endtask

  task automatic wait_valid(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 1);
  endtask

  task automatic drain(input string tag);
    bit empty = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 700 && !empty; i++) begin
      @(negedge clk);
      if (level == 9'd0) empty = 1'b1;
    end
    checkOutput(tag, 32'(empty), 1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] t2_data [3];
    int pushes;
    int pops;
    int push_idx;
    int pop_idx;
    bit pushed;
    bit popped;

    t2_data[0] = 8'h11;
    t2_data[1] = 8'h22;
    t2_data[2] = 8'h33;

    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h77, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_ram_en", ram_en, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_level", level, 0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    tick();

    $display("[TB] test 1: reset mid-traffic");
    for (int i = 1; i <= 5; i++) push_one(8'(8'h40 + i));
    repeat (3) tick();
    checkOutput("t1_level_pre", level, 5);
    checkOutput("t1_m_valid_pre", m_valid, 1);
    @(posedge clk);
    #2;
    applyStimulus(1'b1, 8'h77, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("t1_rst_s_ready", s_ready, 0);
    checkOutput("t1_rst_ram_en", ram_en, 0);
    checkOutput("t1_rst_m_valid", m_valid, 0);
    checkOutput("t1_rst_level", level, 0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    tick();
    push_one(8'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1);
    wait_valid("t1_valid_seen");
    checkOutput("t1_first_pop", m_data, 8'hA5);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] test 2: three pushes then back-to-back pops");
    push_one(8'h11);
    push_one(8'h22);
    @(negedge clk);
    checkOutput("t2_rd_en", ram_en, 1);
    checkOutput("t2_rd_wr", ram_wr, 0);
    checkOutput("t2_rd_addr", ram_addr, 1);
    checkOutput("t2_m_valid_at_grant", m_valid, 0);
    tick();
    @(negedge clk);
    checkOutput("t2_m_valid_after", m_valid, 1);
    checkOutput("t2_m_data_after", m_data, 8'h11);
    tick();
    push_one(8'h33);
    checkOutput("t2_level3", level, 3);
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t2_pop_valid", m_valid, 1);
      checkOutput("t2_pop_data", m_data, t2_data[k]);
      checkOutput("t2_pop_level", level, 32'(3 - k));
      tick();
    end
    @(negedge clk);
    checkOutput("t2_end_valid", m_valid, 0);
    checkOutput("t2_end_level", level, 0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("[TB] test 3: fill to DEPTH+1");
    for (int i = 0; i < 257; i++) push_one(8'(i));
    applyStimulus(1'b1, 8'hEE, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t3_full_s_ready", s_ready, 0);
      checkOutput("t3_full_level", level, 257);
      checkOutput("t3_full_ram_en", ram_en, 0);
      tick();
    end
    checkOutput("t3_full_m_data", m_data, 8'h00);
    applyStimulus(1'b1, 8'hEE, 1'b1);
    @(negedge clk);
    checkOutput("t3_pop_rd_en", ram_en, 1);
    checkOutput("t3_pop_rd_wr", ram_wr, 0);
    checkOutput("t3_pop_rd_addr", ram_addr, 5);
    checkOutput("t3_pop_s_ready", s_ready, 0);
    tick();
    applyStimulus(1'b1, 8'hEE, 1'b0);
    @(negedge clk);
    checkOutput("t3_after_s_ready", s_ready, 1);
    checkOutput("t3_after_m_data", m_data, 8'h01);
    checkOutput("t3_after_level", level, 256);
    tick();
    drain("t3_drained");

    $display("[TB] test 4: contention alternation");
    do_reset();
    push_one(8'h80);
    push_one(8'h81);
    push_one(8'h82);
    checkOutput("t4_level_pre", level, 3);
    applyStimulus(1'b1, 8'h83, 1'b1);
    pushes = 0;
    pops = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("t4_ram_en", ram_en, 1);
      checkOutput("t4_ram_wr", ram_wr, 32'((c % 2) == 0));
      pushed = s_valid && s_ready;
      if (pushed) pushes++;
      if (m_valid && m_ready) pops++;
      tick();
      if (pushed) s_data = s_data + 8'd1;
    end
    checkOutput("t4_push_count", pushes, 10);
    checkOutput("t4_pop_count", pops, 10);
    drain("t4_drained");

    $display("[TB] test 5: 600-byte stream through pointer wrap");
    push_idx = 0;
    pop_idx = 0;
    applyStimulus(1'b1, 8'h00, 1'b1);
    for (int c = 0; c < 3000 && pop_idx < 600; c++) begin
      @(negedge clk);
      pushed = s_valid && s_ready;
      popped = m_valid && m_ready;
      if (popped) begin
        checkOutput("t5_data", m_data, 32'(pop_idx % 256));
        pop_idx++;
      end
      tick();
      if (pushed) begin
        push_idx++;
        s_data = 8'(push_idx);
        if (push_idx == 600) s_valid = 1'b0;
      end
    end
    checkOutput("t5_pop_total", pop_idx, 600);
    checkOutput("t5_push_total", push_idx, 600);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("t5_level_end", level, 0);

    $display("[TB] test 6: write while output displayed");
    do_reset();
    push_one(8'h5A);
    wait_valid("t6_valid_seen");
    checkOutput("t6_m_data_pre", m_data, 8'h5A);
    checkOutput("t6_level_pre", level, 1);
    tick();
    push_one(8'hFF);
    checkOutput("t6_m_data_post", m_data, 8'h5A);
    checkOutput("t6_level_post", level, 2);
    checkOutput("t6_m_valid_post", m_valid, 1);
    @(negedge clk);
    checkOutput("t6_idle_en", ram_en, 0);
    checkOutput("t6_idle_addr", ram_addr, 1);
    checkOutput("t6_idle_din", ram_din, 8'hFF);
    checkOutput("t6_idle_m_data", m_data, 8'h5A);
    tick();
    drain("t6_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
